// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and helpers for the 7-segment scan driver.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (see seg7_scan.sv).
package seg7_pkg;

  localparam int DEF_SCAN_DIV  = 50000;
  localparam int DEF_BLANK_CYC = 2;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_GAP = 2'd1,
    S_ON  = 2'd2
  } state_e;

  // Level that turns a digit common line on.
  function automatic logic sel_on(input bit active_low);
    return ~active_low;
  endfunction

  // Level that keeps a digit common line off.
  function automatic logic sel_off(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: frame data in, scan drive out.
// master drives data/enable, slave is the scanner.
interface seg7_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    EN;
  logic [4*N_DIGITS-1:0]   DATA;
  logic [N_DIGITS-1:0]     DP_IN;
  logic [3:0]              DIGIT_OUT;
  logic                    DP_OUT;
  logic [N_DIGITS-1:0]     DIG_SEL;
  logic                    SCAN_TICK;

  modport master (
    output EN, DATA, DP_IN,
    input  DIGIT_OUT, DP_OUT, DIG_SEL, SCAN_TICK
  );

  modport slave (
    input  EN, DATA, DP_IN,
    output DIGIT_OUT, DP_OUT, DIG_SEL, SCAN_TICK
  );
endinterface

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: per-slot prescaler for the scan driver.
// Counts 0..SCAN_DIV-1 while run is high; clr forces 0.
module seg7_slot_timer #(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1,
  parameter int CW        = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  output logic          gap_end,
  output logic          slot_end,
  output logic [CW-1:0] cnt_nxt
);

  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign gap_end  = (div_cnt_q == GAP_LAST);
  assign slot_end = (div_cnt_q == SLOT_LAST);
  assign cnt_nxt  = div_cnt_d;

  // Next count: wrap at slot end, zero when idle or cleared.
  always_comb begin
    div_cnt_d = '0;
    if (!clr && run && !slot_end)
      div_cnt_d = div_cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (clr) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed common-anode 7-segment scan driver.
// `define SEG7_LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int BLANK_CYC      = DEF_BLANK_CYC,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  seg7_scan_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0] sdp_q, sdp_d;

  logic [3:0] digit_out_q, digit_out_d;
  logic dp_out_q, dp_out_d;
  logic [N_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic scan_tick_q, scan_tick_d;

  logic gap_end;
  logic slot_end;
  logic [CW-1:0] cnt_nxt;
  logic tmr_run;
  logic lit_ok;

  assign tmr_run = (state_q != S_OFF) && bus.EN;

  seg7_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CW        (CW)
  ) u_timer (
    .clk      (CLK),
    .clr      (RST),
    .run      (tmr_run),
    .gap_end  (gap_end),
    .slot_end (slot_end),
    .cnt_nxt  (cnt_nxt)
  );

  // Scan state, digit index and frame shadow next-state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    if (RST) begin
      state_d  = S_OFF;
      idx_d    = '0;
      shadow_d = '0;
      sdp_d    = '0;
    end else if (!bus.EN) begin
      state_d = S_OFF;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          shadow_d = bus.DATA;
          sdp_d    = bus.DP_IN;
          idx_d    = '0;
          state_d  = S_GAP;
        end
        S_GAP: begin
          if (gap_end) state_d = S_ON;
        end
        S_ON: begin
          if (slot_end) begin
            state_d = S_GAP;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              shadow_d = bus.DATA;
              sdp_d    = bus.DP_IN;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = S_OFF;
          idx_d   = '0;
        end
      endcase
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] hi_nz;

  // hi_nz[k]: some shadow nibble at position k or above is non-zero.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    hi_nz = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc      = acc | (|shadow_d[4*k +: 4]);
      hi_nz[k] = acc;
    end
  end

  assign lit_ok = (idx_d == '0) || hi_nz[idx_d];
`else
  assign lit_ok = 1'b1;
`endif

  // Output values for the cycle being entered.
  always_comb begin
    digit_out_d = '0;
    dp_out_d    = 1'b0;
    scan_tick_d = 1'b0;
    for (int k = 0; k < N_DIGITS; k++)
      dig_sel_d[k] = sel_off(SEL_ACTIVE_LOW);
    if (state_d != S_OFF) begin
      digit_out_d = shadow_d[{idx_d, 2'b00} +: 4];
      dp_out_d    = sdp_d[idx_d];
    end
    if (state_d == S_ON) begin
      scan_tick_d = (cnt_nxt == SLOT_LAST);
      for (int k = 0; k < N_DIGITS; k++)
        if (lit_ok && idx_d == IW'(k))
          dig_sel_d[k] = sel_on(SEL_ACTIVE_LOW);
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_OFF;
      idx_q       <= '0;
      shadow_q    <= '0;
      sdp_q       <= '0;
      digit_out_q <= '0;
      dp_out_q    <= 1'b0;
      scan_tick_q <= 1'b0;
      dig_sel_q   <= {N_DIGITS{sel_off(SEL_ACTIVE_LOW)}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      sdp_q       <= sdp_d;
      digit_out_q <= digit_out_d;
      dp_out_q    <= dp_out_d;
      scan_tick_q <= scan_tick_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  assign bus.DIGIT_OUT = digit_out_q;
  assign bus.DP_OUT    = dp_out_q;
  assign bus.DIG_SEL   = dig_sel_q;
  assign bus.SCAN_TICK = scan_tick_q;

endmodule
